// File: rtl/rsreg_pkg.sv
// Shared constants for the set/reset flag bank: conflict-resolution mode codes
// and the helper that applies a mode when set and reset arrive together.
package rsreg_pkg;

   localparam logic [1:0] MODE_HOLD   = 2'd0;
   localparam logic [1:0] MODE_SET    = 2'd1;
   localparam logic [1:0] MODE_RST    = 2'd2;
   localparam logic [1:0] MODE_TOGGLE = 2'd3;

   function automatic logic resolve(input logic [1:0] mode, input logic q);
      logic r;
      r = q;
      case (mode)
         MODE_SET:    r = 1'b1;
         MODE_RST:    r = 1'b0;
         MODE_TOGGLE: r = ~q;
         default:     r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rsreg_bank_if.sv
// Request/status bundle of the flag bank; the master drives requests,
// the slave (the bank) returns flag state, pulses and conflict status.
interface rsreg_bank_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic [WIDTH-1:0] set;
   logic [WIDTH-1:0] rst;
   logic             clr_conflict;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_rise;
   logic [WIDTH-1:0] q_fall;
   logic [WIDTH-1:0] conflict;
   logic [CNT_W-1:0] conflict_cnt;

   modport master (
      output en, set, rst, clr_conflict,
      input  q, q_rise, q_fall, conflict, conflict_cnt
   );

   modport slave (
      input  en, set, rst, clr_conflict,
      output q, q_rise, q_fall, conflict, conflict_cnt
   );
endinterface

// File: rtl/rsreg_cell.sv
// One flag channel: optional edge detection on the requests, next-state
// resolution, and the registered flag with its rise/fall pulses and sticky conflict.
module rsreg_cell
   import rsreg_pkg::*;
#(
   parameter logic [1:0] MODE      = MODE_HOLD,
   parameter bit         EDGE_TRIG = 1'b0,
   parameter logic       INIT_BIT  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic set,
   input  logic rst,
   input  logic clr_conflict,
   output logic q,
   output logic q_rise,
   output logic q_fall,
   output logic conflict,
   output logic hit
);

   logic set_d;
   logic rst_d;
   logic s;
   logic r;
   logic q_next;

   // Effective requests and the flag value they produce; hit marks a set+reset
   // collision this cycle so the top can count it.
   always_comb begin
      s      = EDGE_TRIG ? (set & ~set_d) : set;
      r      = EDGE_TRIG ? (rst & ~rst_d) : rst;
      hit    = en & s & r;
      q_next = q;
      if (en) begin
         case ({s, r})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11:   q_next = resolve(MODE, q);
            default: q_next = q;
         endcase
      end
   end

   // Input history tracks the raw pins even while disabled, so an edge seen
   // with en low is consumed and not replayed later.
   always_ff @(posedge clk) begin
      if (reset) begin
         q        <= INIT_BIT;
         q_rise   <= 1'b0;
         q_fall   <= 1'b0;
         conflict <= 1'b0;
         set_d    <= 1'b0;
         rst_d    <= 1'b0;
      end else begin
         set_d    <= set;
         rst_d    <= rst;
         q        <= q_next;
         q_rise   <= ~q & q_next;
         q_fall   <= q & ~q_next;
         conflict <= (conflict & ~clr_conflict) | hit;
      end
   end

endmodule

// File: rtl/rsreg_bank.sv
// Bank of independent set/reset flags with a saturating count of cycles in
// which at least one channel saw a set+reset collision.
module rsreg_bank
   import rsreg_pkg::*;
#(
   parameter int                     WIDTH     = 4,
   parameter int unsigned            MODE      = 0,
   parameter bit                     EDGE_TRIG = 1'b0,
   parameter logic [WIDTH-1:0]       INIT      = '0,
   parameter int                     CNT_W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   rsreg_bank_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (MODE > 3 || WIDTH < 1 || CNT_W < 1) begin : g_param_check
      $error("rsreg_bank: illegal parameters (MODE<=3, WIDTH>=1, CNT_W>=1)");
   end

   logic [WIDTH-1:0] q_w;
   logic [WIDTH-1:0] rise_w;
   logic [WIDTH-1:0] fall_w;
   logic [WIDTH-1:0] conf_w;
   logic [WIDTH-1:0] hit_w;
   logic [CNT_W-1:0] cnt;
   logic             any_hit;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      rsreg_cell #(
         .MODE      (2'(MODE)),
         .EDGE_TRIG (EDGE_TRIG),
         .INIT_BIT  (INIT[i])
      ) u_cell (
         .clk          (clk),
         .reset        (reset),
         .en           (bus.en),
         .set          (bus.set[i]),
         .rst          (bus.rst[i]),
         .clr_conflict (bus.clr_conflict),
         .q            (q_w[i]),
         .q_rise       (rise_w[i]),
         .q_fall       (fall_w[i]),
         .conflict     (conf_w[i]),
         .hit          (hit_w[i])
      );
   end

   assign any_hit = |hit_w;

   // A fresh collision outranks a clear, so clearing in a colliding cycle leaves 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (any_hit) begin
         if (bus.clr_conflict)  cnt <= CNT_W'(1);
         else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else if (bus.clr_conflict) begin
         cnt <= '0;
      end
   end

   assign bus.q            = q_w;
   assign bus.q_rise       = rise_w;
   assign bus.q_fall       = fall_w;
   assign bus.conflict     = conf_w;
   assign bus.conflict_cnt = cnt;

endmodule

// File: tb/tb_rsreg_bank.sv
// Directed bench for rsreg_bank: one instance per conflict mode plus edge-triggered
// and non-zero-INIT instances, all fed the same request stream.
module tb_rsreg_bank;

   typedef struct {
      string      name;
      logic       rs;
      logic       en;
      logic [3:0] set;
      logic [3:0] rst;
      logic       clr;
      logic [3:0] qh, qs, qr, qt;
      logic [3:0] rise, fall, conf;
      logic [1:0] cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [3:0] set_v = '0;
   logic [3:0] rst_v = '0;
   logic       clr = 1'b0;
   int         checks = 0;
   int         errors = 0;
   vec_t       vq[$];

   always #10 clk = ~clk;

   rsreg_bank_if #(.WIDTH(4), .CNT_W(2)) ifh ();
   rsreg_bank_if #(.WIDTH(4), .CNT_W(2)) ifs ();
   rsreg_bank_if #(.WIDTH(4), .CNT_W(2)) ifr ();
   rsreg_bank_if #(.WIDTH(4), .CNT_W(2)) ift ();
   rsreg_bank_if #(.WIDTH(4), .CNT_W(2)) ife ();
   rsreg_bank_if #(.WIDTH(4), .CNT_W(2)) ifi ();

   assign {ifh.en, ifh.set, ifh.rst, ifh.clr_conflict} = {en, set_v, rst_v, clr};
   assign {ifs.en, ifs.set, ifs.rst, ifs.clr_conflict} = {en, set_v, rst_v, clr};
   assign {ifr.en, ifr.set, ifr.rst, ifr.clr_conflict} = {en, set_v, rst_v, clr};
   assign {ift.en, ift.set, ift.rst, ift.clr_conflict} = {en, set_v, rst_v, clr};
   assign {ife.en, ife.set, ife.rst, ife.clr_conflict} = {en, set_v, rst_v, clr};
   assign {ifi.en, ifi.set, ifi.rst, ifi.clr_conflict} = {en, set_v, rst_v, clr};

   rsreg_bank #(.WIDTH(4), .MODE(0), .EDGE_TRIG(1'b0), .INIT(4'b0000), .CNT_W(2))
      dut_hold (.clk(clk), .reset(reset), .bus(ifh));
   rsreg_bank #(.WIDTH(4), .MODE(1), .EDGE_TRIG(1'b0), .INIT(4'b0000), .CNT_W(2))
      dut_set (.clk(clk), .reset(reset), .bus(ifs));
   rsreg_bank #(.WIDTH(4), .MODE(2), .EDGE_TRIG(1'b0), .INIT(4'b0000), .CNT_W(2))
      dut_rst (.clk(clk), .reset(reset), .bus(ifr));
   rsreg_bank #(.WIDTH(4), .MODE(3), .EDGE_TRIG(1'b0), .INIT(4'b0000), .CNT_W(2))
      dut_tog (.clk(clk), .reset(reset), .bus(ift));
   rsreg_bank #(.WIDTH(4), .MODE(0), .EDGE_TRIG(1'b1), .INIT(4'b0000), .CNT_W(2))
      dut_edge (.clk(clk), .reset(reset), .bus(ife));
   rsreg_bank #(.WIDTH(4), .MODE(0), .EDGE_TRIG(1'b0), .INIT(4'b1010), .CNT_W(2))
      dut_init (.clk(clk), .reset(reset), .bus(ifi));

   task automatic addVec(input string n, input logic rs, input logic e,
                         input logic [3:0] s, input logic [3:0] r, input logic c,
                         input logic [3:0] qh, input logic [3:0] qs,
                         input logic [3:0] qr, input logic [3:0] qt,
                         input logic [3:0] rise, input logic [3:0] fall,
                         input logic [3:0] conf, input logic [1:0] cnt);
      vec_t v;
      v.name = n; v.rs = rs; v.en = e; v.set = s; v.rst = r; v.clr = c;
      v.qh = qh; v.qs = qs; v.qr = qr; v.qt = qt;
      v.rise = rise; v.fall = fall; v.conf = conf; v.cnt = cnt;
      vq.push_back(v);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic applyStimulus(input logic rs, input logic e, input logic [3:0] s,
                                input logic [3:0] r, input logic c);
      @(negedge clk);
      reset = rs; en = e; set_v = s; rst_v = r; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string n, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", n, actual, expected);
      end
   endtask

   initial begin
      //      name     rs en set  rst clr  qh    qs    qr    qt    rise  fall  conf  cnt
      addVec("rst0",   1, 1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("rst1",   1, 1, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("set0",   0, 1, 4'h1, 4'h0, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 2'd0);
      addVec("hold1",  0, 1, 4'h1, 4'h0, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("hold2",  0, 1, 4'h1, 4'h0, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("hold3",  0, 1, 4'h1, 4'h0, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("clr0",   0, 1, 4'h0, 4'h1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 2'd0);
      addVec("idle",   0, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("dis_s",  0, 0, 4'hF, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("dis_sr", 0, 0, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("set5",   0, 1, 4'h5, 4'h0, 0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 2'd0);
      addVec("conf1",  0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'hF, 2'd1);
      addVec("conf2",  0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hF, 4'h0, 4'h5, 4'h0, 4'h0, 4'hF, 2'd2);
      addVec("conf3",  0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'hF, 2'd3);
      addVec("conf4",  0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hF, 4'h0, 4'h5, 4'h0, 4'h0, 4'hF, 2'd3);
      addVec("conf5",  0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'hF, 2'd3);
      addVec("clrc",   0, 1, 4'h0, 4'h0, 1, 4'h5, 4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 2'd0);
      addVec("clr_cf", 0, 1, 4'h1, 4'h1, 1, 4'h5, 4'hF, 4'h0, 4'hB, 4'h0, 4'h0, 4'h1, 2'd1);
      addVec("sticky", 0, 1, 4'h0, 4'h0, 0, 4'h5, 4'hF, 4'h0, 4'hB, 4'h0, 4'h0, 4'h1, 2'd1);

      foreach (vq[i]) begin
         applyStimulus(vq[i].rs, vq[i].en, vq[i].set, vq[i].rst, vq[i].clr);
         checkOutput({vq[i].name, " q_hold"},   32'(ifh.q),            32'(vq[i].qh));
         checkOutput({vq[i].name, " q_set"},    32'(ifs.q),            32'(vq[i].qs));
         checkOutput({vq[i].name, " q_rst"},    32'(ifr.q),            32'(vq[i].qr));
         checkOutput({vq[i].name, " q_tog"},    32'(ift.q),            32'(vq[i].qt));
         checkOutput({vq[i].name, " q_rise"},   32'(ifh.q_rise),       32'(vq[i].rise));
         checkOutput({vq[i].name, " q_fall"},   32'(ifh.q_fall),       32'(vq[i].fall));
         checkOutput({vq[i].name, " conflict"}, 32'(ifh.conflict),     32'(vq[i].conf));
         checkOutput({vq[i].name, " cnt"},      32'(ifh.conflict_cnt), 32'(vq[i].cnt));
      end

      // Non-zero INIT under reset with set held high.
      applyStimulus(1, 1, 4'hF, 4'h0, 0);
      applyStimulus(1, 1, 4'hF, 4'h0, 0);
      checkOutput("init q",        32'(ifi.q),            32'h A);
      checkOutput("init q_rise",   32'(ifi.q_rise),       32'h0);
      checkOutput("init conflict", 32'(ifi.conflict),     32'h0);
      checkOutput("init cnt",      32'(ifi.conflict_cnt), 32'h0);

      // Edge-triggered channel 2: held set acts once, reset edge clears, disabled edge is lost.
      applyStimulus(1, 1, 4'h0, 4'h0, 0);
      applyStimulus(0, 1, 4'h4, 4'h0, 0);
      checkOutput("edge set q",    32'(ife.q),      32'h4);
      checkOutput("edge set rise", 32'(ife.q_rise), 32'h4);
      applyStimulus(0, 1, 4'h4, 4'h0, 0);
      checkOutput("edge held q",   32'(ife.q),      32'h4);
      checkOutput("edge held rise", 32'(ife.q_rise), 32'h0);
      applyStimulus(0, 1, 4'h4, 4'h4, 0);
      checkOutput("edge rst q",    32'(ife.q),      32'h0);
      checkOutput("edge rst fall", 32'(ife.q_fall), 32'h4);
      checkOutput("edge rst conf", 32'(ife.conflict), 32'h0);
      applyStimulus(0, 1, 4'h4, 4'h0, 0);
      checkOutput("edge stay0 q",  32'(ife.q),      32'h0);
      applyStimulus(0, 1, 4'h0, 4'h0, 0);
      applyStimulus(0, 0, 4'h1, 4'h0, 0);
      checkOutput("edge dis q",    32'(ife.q),      32'h0);
      applyStimulus(0, 1, 4'h1, 4'h0, 0);
      checkOutput("edge lost q",   32'(ife.q),      32'h0);
      applyStimulus(0, 1, 4'h0, 4'h0, 0);
      applyStimulus(0, 1, 4'h1, 4'h0, 0);
      checkOutput("edge new q",    32'(ife.q),      32'h1);

      // Reset in the middle of operation beats a simultaneous reset request, no fall pulses.
      applyStimulus(0, 1, 4'hF, 4'h0, 0);
      checkOutput("mid pre q",     32'(ifh.q),      32'hF);
      applyStimulus(1, 1, 4'h0, 4'h3, 0);
      checkOutput("mid q",         32'(ifh.q),      32'h0);
      checkOutput("mid fall",      32'(ifh.q_fall), 32'h0);
      checkOutput("mid init q",    32'(ifi.q),      32'hA);
      checkOutput("mid init fall", 32'(ifi.q_fall), 32'h0);
      applyStimulus(0, 1, 4'h3, 4'h0, 0);
      checkOutput("post q",        32'(ifh.q),      32'h3);
      checkOutput("post rise",     32'(ifh.q_rise), 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
